ldpc_frame_ctrl: RTL
====================

// Module: ldpc_frame_ctrl
// PURPOSE
// - Frame sequencer wrapped around the 360-parallel LDPC parity accumulator (encoder5).
// - Upstream: accepts a serial info-bit stream and drives din_valid/din/counter.
// - Downstream: reads the 360 parity bits back out via out_addr/data_valid_check and
//   applies the final running-XOR parity step.
// - Emits one serial codeword per frame: K_BITS systematic bits, then P_BITS parity bits.
// PARAMETERS
// K_BITS    4320  info bits per frame (12 groups x 360)
// P_BITS    360   parity bits per frame; equals encoder accumulator width
// CNT_W     13    width of enc_counter
// ADDR_W    9     width of enc_out_addr
// CLR_CYC   2     cycles enc_rst_n is held low between frames (ROM addr 0 settles)
// ACCUM_EN  1     1: out parity j = enc_dout_j ^ out parity j-1; 0: raw enc_dout
// PORTS
// clk           in   1       clock
// rst_n         in   1       synchronous active-low reset
// s_valid       in   1       info bit valid
// s_ready       out  1       info bit accepted when s_valid & s_ready
// s_data        in   1       info bit
// enc_rst_n     out  1       encoder reset: rst_n & ~clear
// enc_din_valid out  1       = s_valid & s_ready (combinational)
// enc_din       out  1       = s_data (combinational)
// enc_counter   out  CNT_W   index 0..K_BITS-1 of bit currently on enc_din
// enc_out_addr  out  ADDR_W  parity address, issued P_BITS-1 down to 0
// enc_dvc       out  1       data_valid_check to encoder
// enc_dout      in   1       encoder parity bit, valid 1 cycle after its address
// m_valid       out  1       output codeword bit valid (no backpressure)
// m_data        out  1       codeword bit
// m_sof         out  1       with first systematic bit of a frame
// m_eof         out  1       with last parity bit of a frame
// busy          out  1       high in every state except LOAD with enc_counter==0
// BEHAVIOUR
// - FSM: CLEAR -> LOAD -> PARITY -> DRAIN -> CLEAR. Reset forces CLEAR, clr_cnt=0.
// - Reset values: s_ready=0, enc_rst_n=0, enc_counter=0, enc_out_addr=P_BITS-1,
//   enc_dvc=0, m_valid=0, m_data=0, m_sof=0, m_eof=0, acc=0.
// - CLEAR: enc_rst_n=0, enc_counter=0, s_ready=0. Exit to LOAD after CLR_CYC cycles.
// - LOAD: s_ready=1. On each accept enc_counter increments; on a stall it holds.
//   Every accepted bit is also registered to m_data with m_valid=1 (1-cycle latency).
//   m_sof=1 on the bit accepted with enc_counter==0. The accept at K_BITS-1 goes to
//   PARITY with s_ready=0 on the next cycle; enc_counter wraps to 0.
// - PARITY: enc_dvc=1 for exactly P_BITS cycles; enc_out_addr goes P_BITS-1..0,
//   one per cycle. Then DRAIN.
// - Parity pipeline: address at cycle t -> enc_dout at t+1 -> m_data at t+2.
//   With ACCUM_EN: acc <= acc ^ enc_dout; m_data = acc ^ enc_dout. acc cleared at
//   entry to PARITY.
// - DRAIN: 2 cycles, enc_dvc=0; flushes the last parity bits. m_eof is high with
//   parity bit P_BITS-1 (the last out). Then CLEAR.
// - m_valid is continuous during parity output (P_BITS consecutive cycles).
//   Between systematic and parity bits there is a gap of exactly 1 idle cycle.
// - s_valid while s_ready=0: ignored. No bit is lost; the source holds.
// - rst_n low mid-frame: partial frame is dropped and outputs take reset values
//   next cycle. No m_eof is emitted for a partial frame.
// - enc_counter never exceeds K_BITS-1; enc_out_addr never exceeds P_BITS-1.
// STRUCTURE
// - Shared pkg/include: K_BITS, P_BITS, CNT_W, ADDR_W and FSM state encodings
//   (shared with the encoder top).
// - Flat RTL: one FSM plus counters.
// - One natural sub-module: ldpc_parity_accum (acc register, ACCUM_EN mux, output
//   register).
// TESTING
// - Reset, then a stream of all zeros (K_BITS bits, s_valid=1):
//   4320 zero systematic bits, then 360 zero parity bits; m_sof/m_eof once each.
// - Single 1 at index 0 against a stub encoder returning ROM row 0:
//   parity = running XOR of row 0, emitted MSB address first.
// - Random s_valid duty 30%: enc_counter holds on stalls; systematic output equals
//   the input bit-exact; total m_valid count = 4680.
// - Two back-to-back frames: enc_rst_n low exactly CLR_CYC cycles between them;
//   frame 2 parity is independent of frame 1.
// - rst_n pulse at enc_counter=2000: no m_eof; next frame encodes correctly.
// - ACCUM_EN=0 with enc_dout stub = address parity: m_data equals the stub
//   sequence, delayed 2 cycles.

Source files
------------

// File: rtl/ldpc_frame_ctrl_pkg.sv
// Shared sizes, FSM encodings and the output beat record for the LDPC frame sequencer.
// Also visible to the encoder top so both sides agree on frame geometry.
package ldpc_frame_ctrl_pkg;

  localparam int K_BITS    = 4320;
  localparam int P_BITS    = 360;
  localparam int CNT_W     = 13;
  localparam int ADDR_W    = 9;
  localparam int CLR_CYC   = 2;
  localparam int DRAIN_CYC = 2;
  localparam int PH_W      = 2;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(K_BITS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(P_BITS - 1);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_PARITY = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic vld;
    logic dat;
    logic sof;
    logic eof;
  } beat_t;

endpackage

// File: rtl/ldpc_parity_accum.sv
// Registers systematic bits and running-XOR parity bits onto the codeword output; 1-cycle latency.
// No backpressure: every valid input produces an output beat on the following cycle.
module ldpc_parity_accum
  import ldpc_frame_ctrl_pkg::*;
#(
  parameter bit ACCUM_EN = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_clr,
  input  logic  i_sys_vld,
  input  logic  i_sys_dat,
  input  logic  i_sys_sof,
  input  logic  i_par_vld,
  input  logic  i_par_dat,
  input  logic  i_par_last,
  output beat_t o_beat
);

  logic  r_acc;
  beat_t r_beat;
  logic  w_par_bit;

  // With ACCUM_EN each parity bit is XORed with every parity bit emitted before it.
  assign w_par_bit = ACCUM_EN ? (r_acc ^ i_par_dat) : i_par_dat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= 1'b0;
      r_beat <= '0;
    end else begin
      r_beat.vld <= i_sys_vld | i_par_vld;
      r_beat.sof <= i_sys_vld & i_sys_sof;
      r_beat.eof <= i_par_vld & i_par_last;
      if (i_sys_vld) begin
        r_beat.dat <= i_sys_dat;
      end else if (i_par_vld) begin
        r_beat.dat <= w_par_bit;
      end
      if (i_clr) begin
        r_acc <= 1'b0;
      end else if (i_par_vld) begin
        r_acc <= r_acc ^ i_par_dat;
      end
    end
  end

  assign o_beat = r_beat;

endmodule

// File: rtl/ldpc_frame_ctrl.sv
// Frame sequencer around the LDPC parity accumulator: loads K info bits, reads P parity bits back.
// Systematic out 1 cycle after accept, parity out 2 cycles after address; source stalls via s_ready.
module ldpc_frame_ctrl
  import ldpc_frame_ctrl_pkg::*;
#(
  parameter bit ACCUM_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic              i_s_data,
  output logic              o_enc_rst_n,
  output logic              o_enc_din_valid,
  output logic              o_enc_din,
  output logic [CNT_W-1:0]  o_enc_counter,
  output logic [ADDR_W-1:0] o_enc_out_addr,
  output logic              o_enc_dvc,
  input  logic              i_enc_dout,
  output logic              o_m_valid,
  output logic              o_m_data,
  output logic              o_m_sof,
  output logic              o_m_eof,
  output logic              o_busy
);

  state_t            r_state;
  state_t            w_next;
  logic [PH_W-1:0]   r_ph_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_par_vld;
  logic              r_par_last;
  logic              w_ready;
  logic              w_dvc;
  logic              w_clear;
  logic              w_accept;
  logic              w_busy;
  beat_t             w_beat;

  assign w_accept = i_s_valid & w_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR:  if (r_ph_cnt == PH_W'(CLR_CYC - 1)) w_next = ST_LOAD;
      ST_LOAD:   if (w_accept && (r_cnt == CNT_LAST)) w_next = ST_PARITY;
      ST_PARITY: if (r_addr == '0) w_next = ST_DRAIN;
      ST_DRAIN:  if (r_ph_cnt == PH_W'(DRAIN_CYC - 1)) w_next = ST_CLEAR;
      default:   w_next = ST_CLEAR;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_dvc   = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      ST_CLEAR:  w_clear = 1'b1;
      ST_LOAD:   w_ready = 1'b1;
      ST_PARITY: w_dvc   = 1'b1;
      default:   ;
    endcase
  end

  // Phase counter times the fixed-length CLEAR and DRAIN states; restarts on every transition.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state != w_next)) begin
      r_ph_cnt <= '0;
    end else if ((r_state == ST_CLEAR) || (r_state == ST_DRAIN)) begin
      r_ph_cnt <= r_ph_cnt + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !w_dvc) begin
      r_addr <= ADDR_LAST;
    end else begin
      r_addr <= (r_addr == '0) ? ADDR_LAST : r_addr - ADDR_W'(1);
    end
  end

  // Encoder answers one cycle after the address, so qualify its data with a delayed strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_vld  <= 1'b0;
      r_par_last <= 1'b0;
    end else begin
      r_par_vld  <= w_dvc;
      r_par_last <= w_dvc && (r_addr == '0);
    end
  end

  assign w_busy = !(w_ready && (r_cnt == '0));

  ldpc_parity_accum #(
    .ACCUM_EN (ACCUM_EN)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_ready),
    .i_sys_vld  (w_accept),
    .i_sys_dat  (i_s_data),
    .i_sys_sof  (r_cnt == '0),
    .i_par_vld  (r_par_vld),
    .i_par_dat  (i_enc_dout),
    .i_par_last (r_par_last),
    .o_beat     (w_beat)
  );

  assign o_s_ready       = w_ready;
  assign o_enc_rst_n     = rst_n & ~w_clear;
  assign o_enc_din_valid = w_accept;
  assign o_enc_din       = i_s_data;
  assign o_enc_counter   = r_cnt;
  assign o_enc_out_addr  = r_addr;
  assign o_enc_dvc       = w_dvc;
  assign o_m_valid       = w_beat.vld;
  assign o_m_data        = w_beat.dat;
  assign o_m_sof         = w_beat.sof;
  assign o_m_eof         = w_beat.eof;
  assign o_busy          = w_busy;

endmodule
